// File: rtl/instruction_memory_hs.sv
`timescale 1ns/1ps
// Instruction memory with valid/ready fetch and response channels, a program-load
// port and a one-way write lock. Optional per-word even parity under IMEM_PARITY_EN.
module instruction_memory_hs #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 1024,
  parameter logic [DATA_W-1:0] NOP_WORD = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  // Every channel here is valid/ready: a transfer happens on a rising edge where
  // valid and ready are both high; a source holds its payload until then.
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_pc,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_instr,
  output logic [ADDR_W-1:0] rsp_pc,
  output logic [1:0]        rsp_fault,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              lock_req,
  output logic              locked,
  output logic              ld_err,
  output logic              init_done,
`ifdef IMEM_PARITY_EN
  input  logic              parity_inj,
`endif
  output logic [1:0]        dbg_state
);

  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [1:0] FAULT_OK    = 2'd0;
  localparam logic [1:0] FAULT_MISAL = 2'd1;
  localparam logic [1:0] FAULT_RANGE = 2'd2;
  localparam logic [1:0] FAULT_PAR   = 2'd3;

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_OPEN   = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_init_cnt;

  logic [DATA_W-1:0]  r_mem [DEPTH];

  logic               r_rsp_valid;
  logic [DATA_W-1:0]  r_rsp_instr;
  logic [ADDR_W-1:0]  r_rsp_pc;
  logic [1:0]         r_rsp_fault;
  logic               r_ld_err;

  logic [IDX_W-1:0]   w_req_idx;
  logic [IDX_W-1:0]   w_ld_idx;
  logic               w_req_misal;
  logic               w_req_oor;
  logic               w_ld_oor;
  logic               w_req_ready;
  logic               w_ld_ready;
  logic               w_req_fire;
  logic               w_ld_fire;
  logic               w_ld_accept;
  logic               w_ld_reject;
  logic               w_wr_en;
  logic [IDX_W-1:0]   w_wr_idx;
  logic [DATA_W-1:0]  w_wr_data;
  logic [DATA_W-1:0]  w_rd_word;
  logic               w_rd_par_err;
  logic [1:0]         w_fault;
  logic [DATA_W-1:0]  w_rsp_instr_nxt;
  logic               w_unused_ld_lsbs;

  // ---------------------------------------------------------------------------
  // Address decode: word index from bits above the byte offset; any set bit above
  // the index field is out of range.
  // ---------------------------------------------------------------------------
  assign w_req_idx        = req_pc[IDX_W+1:2];
  assign w_ld_idx         = ld_addr[IDX_W+1:2];
  assign w_req_misal      = |req_pc[1:0];
  assign w_unused_ld_lsbs = ^ld_addr[1:0];

  generate
    if (ADDR_W > IDX_W + 2) begin : g_hi_bits
      assign w_req_oor = |req_pc[ADDR_W-1:IDX_W+2];
      assign w_ld_oor  = |ld_addr[ADDR_W-1:IDX_W+2];
    end else begin : g_no_hi_bits
      assign w_req_oor = 1'b0;
      assign w_ld_oor  = 1'b0;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = 1'b0;
    w_ld_ready  = 1'b0;
    unique case (r_state)
      S_INIT: begin
        if (r_init_cnt == IDX_W'(DEPTH - 1)) begin
          w_state_nxt = S_OPEN;
        end
      end
      S_OPEN: begin
        w_req_ready = !r_rsp_valid || rsp_ready;
        w_ld_ready  = 1'b1;
        if (lock_req) begin
          w_state_nxt = S_LOCKED;
        end
      end
      S_LOCKED: begin
        w_req_ready = !r_rsp_valid || rsp_ready;
        w_ld_ready  = 1'b1;
      end
      default: begin
        w_state_nxt = S_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_init_cnt <= '0;
    end else if (r_state == S_INIT) begin
      r_init_cnt <= r_init_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Single write port shared by the init fill and the program loader. Loads that
  // fire while LOCKED or outside the array are consumed but never written.
  // ---------------------------------------------------------------------------
  assign w_req_fire  = req_valid && w_req_ready;
  assign w_ld_fire   = ld_valid && w_ld_ready;
  assign w_ld_accept = w_ld_fire && (r_state == S_OPEN) && !w_ld_oor;
  assign w_ld_reject = w_ld_fire && ((r_state == S_LOCKED) || w_ld_oor);

  assign w_wr_en   = !rst && ((r_state == S_INIT) || w_ld_accept);
  assign w_wr_idx  = (r_state == S_INIT) ? r_init_cnt : w_ld_idx;
  assign w_wr_data = (r_state == S_INIT) ? NOP_WORD : ld_data;

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_idx] <= w_wr_data;
    end
  end

  // Read sees the array before this edge's write lands: read-before-write.
  assign w_rd_word = r_mem[w_req_idx];

`ifdef IMEM_PARITY_EN
  logic r_par [DEPTH];
  logic w_wr_par;

  assign w_wr_par = (r_state == S_INIT) ? (^NOP_WORD) : ((^ld_data) ^ parity_inj);

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_par[w_wr_idx] <= w_wr_par;
    end
  end

  assign w_rd_par_err = (^w_rd_word) != r_par[w_req_idx];
`else
  assign w_rd_par_err = 1'b0;
`endif

  always_comb begin
    w_fault = FAULT_OK;
    if (w_req_misal) begin
      w_fault = FAULT_MISAL;
    end else if (w_req_oor) begin
      w_fault = FAULT_RANGE;
    end else if (w_rd_par_err) begin
      w_fault = FAULT_PAR;
    end
  end

  assign w_rsp_instr_nxt = (w_fault != FAULT_OK) ? NOP_WORD : w_rd_word;

  // ---------------------------------------------------------------------------
  // Response register: loads on an accepted fetch, clears valid when consumed,
  // and otherwise holds every field so a stalled consumer sees stable data.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_instr <= NOP_WORD;
      r_rsp_pc    <= '0;
      r_rsp_fault <= FAULT_OK;
    end else if (w_req_fire) begin
      r_rsp_valid <= 1'b1;
      r_rsp_instr <= w_rsp_instr_nxt;
      r_rsp_pc    <= req_pc;
      r_rsp_fault <= w_fault;
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ld_err <= 1'b0;
    end else begin
      r_ld_err <= w_ld_reject;
    end
  end

  assign req_ready = w_req_ready;
  assign ld_ready  = w_ld_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_instr = r_rsp_instr;
  assign rsp_pc    = r_rsp_pc;
  assign rsp_fault = r_rsp_fault;
  assign ld_err    = r_ld_err;
  assign locked    = (r_state == S_LOCKED);
  assign init_done = (r_state != S_INIT);
  assign dbg_state = r_state;

endmodule

// File: doc/instruction_memory_hs.md
Name: instruction_memory_hs

Overview:
Parametrised, synchronous instruction memory with valid/ready fetch and response channels, a program-load port, and a one-way write lock for the secured core. After reset, an init sequencer fills every word with NOP. Fetches return registered data with 1-cycle latency and a fault code for misaligned or out-of-range PCs. Sits between the fetch stage and the program loader.

Parameters:
ADDR_W, 32, width of fetch PC and load address (byte addresses)
DATA_W, 32, instruction word width
DEPTH, 1024, number of words; must be a power of two, at least 2
NOP_WORD, 32'h00000013, fill value and faulted-response value (addi x0,x0,0)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
req_valid  in  1  fetch request valid
req_ready  out  1  fetch request accepted when high with req_valid
req_pc  in  ADDR_W  fetch byte address
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer accepts response
rsp_instr  out  DATA_W  fetched word
rsp_pc  out  ADDR_W  PC of the response
rsp_fault  out  2  0=ok, 1=misaligned, 2=out of range, 3=parity
ld_valid  in  1  load write valid
ld_ready  out  1  load write accepted
ld_addr  in  ADDR_W  load byte address (word-aligned; bits [1:0] ignored)
ld_data  in  DATA_W  load data
lock_req  in  1  pulse or level; moves OPEN to LOCKED
locked  out  1  high in LOCKED
ld_err  out  1  1-cycle pulse on rejected load
init_done  out  1  high once INIT completes

Behaviour:
- Word index is req_pc[log2(DEPTH)+1:2]. Out of range means any req_pc bit above log2(DEPTH)+1 is set.
- Reset values: rsp_valid=0, rsp_instr=NOP_WORD, rsp_pc=0, rsp_fault=0, locked=0, ld_err=0, init_done=0, state=INIT, init counter=0.
- FSM states:
  - INIT: writes NOP_WORD to word[cnt] and increments cnt each cycle. After DEPTH cycles, moves to OPEN and sets init_done=1. req_ready=0 and ld_ready=0 throughout.
  - OPEN: ld_ready=1. An accepted load writes ld_data to word[ld_addr index]. An out-of-range ld_addr is dropped and pulses ld_err. lock_req=1 moves to LOCKED on the next cycle; a load in that same cycle is still written.
  - LOCKED: ld_ready=1. Every ld_valid is dropped and pulses ld_err. The state leaves LOCKED only on rst.
- req_ready = (state != INIT) && (!rsp_valid || rsp_ready).
- Fetch accepted in cycle N produces rsp_valid=1 in cycle N+1, with rsp_pc=req_pc and the instruction/fault for that PC.
- Fault priority: misaligned (req_pc[1:0] != 0) > out of range > parity. Any fault forces rsp_instr=NOP_WORD.
- While rsp_valid && !rsp_ready, all rsp_* outputs hold stable.
- Back-to-back fetches sustain 1 per cycle when rsp_ready=1.
- rsp_valid drops only when it is consumed and no new request is accepted.
- Load and fetch to the same word in the same cycle: the fetch returns the old contents (read-before-write).
- rst mid-operation: the in-flight response is discarded, rsp_valid=0, the lock is cleared, and INIT reruns (memory is refilled).

Optional Feature:
- IMEM_PARITY_EN defined:
  - Each word stores an extra even-parity bit, written on init and on every load.
  - Extra input port parity_inj (1 bit): when high with an accepted load, the stored parity is inverted.
  - A read whose parity mismatches with no higher-priority fault gives rsp_fault=3 and rsp_instr=NOP_WORD.
- Undefined: no parity storage and no parity_inj port; rsp_fault never equals 3.

Test Plan:
- Reset, then count cycles → req_ready=0 and init_done=0 for exactly 1024 cycles, then both 1. A fetch of pc=0x40 returns 32'h00000013 with fault 0.
- Load 0x000=32'h00A00093 and 0x004=32'h00500113, then fetch 0x0 and 0x4 back-to-back with rsp_ready=1 → two consecutive rsp_valid cycles returning those words, with rsp_pc 0x0 and 0x4.
- Fetch 0x6 → fault 1, instr NOP. Fetch 0x1000 → fault 2, instr NOP.
- Stall: hold rsp_ready=0 for 3 cycles after a fetch → outputs stable, req_ready=0. Release → the next request is accepted in the same cycle.
- Pulse lock_req, then load 0x0=32'hDEADBEEF → ld_err pulses once, and a fetch of 0x0 still returns 32'h00A00093. Assert rst → locked=0 and INIT reruns.
- With IMEM_PARITY_EN: load 0x8=32'h002081B3 with parity_inj=1, then fetch 0x8 → fault 3, instr NOP. Reload without injection → fault 0, correct word.
